// File: rtl/cordic_angle_sequencer.sv
// Steps through circular (atan 2^-k) or hyperbolic (artanh 2^-k) elementary angles,
// one per accepted handshake; hyperbolic runs repeat shifts 4 and 13.
module cordic_angle_sequencer #(
  parameter int WORD_LENGTH    = 16,
  parameter int ADDRESS_LENGTH = 4,
  parameter int N_ITER         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      ready,
  output logic                      valid,
  output logic [ADDRESS_LENGTH-1:0] shift,
  output logic [ADDRESS_LENGTH-1:0] step,
  output logic [WORD_LENGTH-1:0]    angle,
  output logic                      last,
  output logic                      busy,
  output logic                      done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int S = 32 - WORD_LENGTH;
  localparam logic [31:0] RND = (32'd1 << S) >> 1;
  localparam logic [ADDRESS_LENGTH-1:0] LAST_STEP = ADDRESS_LENGTH'(N_ITER - 1);
  localparam logic [ADDRESS_LENGTH-1:0] SHIFT_MAX = '1;

  // Master constants round(f(2^-k) * 2^30); beyond k=9 both reduce to 2^(30-k).
  function automatic logic [31:0] atan_m(input logic [4:0] k);
    case (k)
      5'd0:    atan_m = 32'd843314857;
      5'd1:    atan_m = 32'd497837829;
      5'd2:    atan_m = 32'd263043837;
      5'd3:    atan_m = 32'd133525159;
      5'd4:    atan_m = 32'd67021687;
      5'd5:    atan_m = 32'd33543516;
      5'd6:    atan_m = 32'd16775851;
      5'd7:    atan_m = 32'd8388437;
      5'd8:    atan_m = 32'd4194283;
      5'd9:    atan_m = 32'd2097149;
      5'd31:   atan_m = 32'd0;
      default: atan_m = 32'h4000_0000 >> k;
    endcase
  endfunction

  function automatic logic [31:0] atanh_m(input logic [4:0] k);
    case (k)
      5'd0:    atanh_m = 32'd0;
      5'd1:    atanh_m = 32'd589812981;
      5'd2:    atanh_m = 32'd274247419;
      5'd3:    atanh_m = 32'd134923406;
      5'd4:    atanh_m = 32'd67196451;
      5'd5:    atanh_m = 32'd33565361;
      5'd6:    atanh_m = 32'd16778582;
      5'd7:    atanh_m = 32'd8388779;
      5'd8:    atanh_m = 32'd4194325;
      5'd9:    atanh_m = 32'd2097155;
      5'd31:   atanh_m = 32'd1;
      default: atanh_m = 32'h4000_0000 >> k;
    endcase
  endfunction

  logic [0:0]                state_q, state_d;
  logic                      mode_q, mode_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      last_q, last_d;
  logic                      rep_q, rep_d;
  logic [ADDRESS_LENGTH-1:0] step_q, step_d;
  logic [ADDRESS_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0]    angle_q, angle_d;
  logic [4:0]                shift_w;
  logic [31:0]               m_sel;
  logic                      load;

  assign shift_w = 5'(shift_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    last_d  = last_q;
    rep_d   = rep_q;
    step_d  = step_q;
    shift_d = shift_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          step_d  = '0;
          shift_d = mode ? ADDRESS_LENGTH'(1) : '0;
          rep_d   = 1'b0;
          last_d  = (LAST_STEP == '0);
          load    = 1'b1;
        end
      end
      default: begin
        if (valid_q && ready) begin
          if (step_q == LAST_STEP) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
            last_d = (step_d == LAST_STEP);
            load   = 1'b1;
            if (!mode_q) begin
              shift_d = step_q + 1'b1;
            end else if (!rep_q && (shift_w == 5'd4 || shift_w == 5'd13)) begin
              // Hold the shift for one extra step so the hyperbolic run converges.
              rep_d = 1'b1;
            end else begin
              rep_d   = 1'b0;
              shift_d = (shift_q == SHIFT_MAX) ? SHIFT_MAX : shift_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    m_sel   = mode_d ? atanh_m(5'(shift_d)) : atan_m(5'(shift_d));
    angle_d = load ? WORD_LENGTH'((m_sel + RND) >> S) : angle_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      rep_q   <= 1'b0;
      step_q  <= '0;
      shift_q <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      step_q  <= step_d;
      shift_q <= shift_d;
      angle_q <= angle_d;
    end
  end

  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign last  = last_q;
  assign step  = step_q;
  assign shift = shift_q;
  assign angle = angle_q;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Bench for cordic_angle_sequencer: runs are checked against a real-arithmetic angle
// model and a queue-built shift sequence, plus fixed reference constants.
module tb_cordic_angle_sequencer;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic        start, mode, ready;
  logic        valid, last, busy, done;
  logic [3:0]  shift, step;
  logic [15:0] angle;

  logic        pstart, pmode, pready;
  logic        v12, l12, b12, d12;
  logic [3:0]  sh12, st12;
  logic [11:0] a12;
  logic        v32, l32, b32, d32;
  logic [3:0]  sh32, st32;
  logic [31:0] a32;

  int vectors = 0;
  int errors  = 0;
  int fixed_q[$];

  cordic_angle_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
    .valid(valid), .shift(shift), .step(step), .angle(angle),
    .last(last), .busy(busy), .done(done)
  );

  cordic_angle_sequencer #(.WORD_LENGTH(12), .ADDRESS_LENGTH(4), .N_ITER(4)) dut12 (
    .clk(clk), .rst(rst), .start(pstart), .mode(pmode), .ready(pready),
    .valid(v12), .shift(sh12), .step(st12), .angle(a12),
    .last(l12), .busy(b12), .done(d12)
  );

  cordic_angle_sequencer #(.WORD_LENGTH(32), .ADDRESS_LENGTH(4), .N_ITER(16)) dut32 (
    .clk(clk), .rst(rst), .start(pstart), .mode(pmode), .ready(pready),
    .valid(v32), .shift(sh32), .step(st32), .angle(a32),
    .last(l32), .busy(b32), .done(d32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected angle straight from the math: round(f(2^-k)*2^30), then rounded down to wl bits.
  function automatic longint exp_angle(input bit hyp, input int k, input int wl);
    real x, f;
    longint m;
    int s;
    x = 2.0 ** (-k);
    f = hyp ? $atanh(x) : $atan(x);
    m = longint'($floor(f * 1073741824.0 + 0.5));
    s = 32 - wl;
    if (s == 0) return m;
    return (m + (longint'(1) << (s - 1))) >> s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic check_run(input bit m, input int ready_pct, input int stall_at,
                           input bit poke, input bit chain, input bit chain_mode);
    int exp_sh[$];
    int idx = 0;
    int cycles = 0;
    int stalls = 0;
    int k = 1;
    logic rdy;
    logic [15:0] ea;
    if (!m) begin
      for (int i = 0; i < N; i++) exp_sh.push_back(i);
    end else begin
      while (exp_sh.size() < N) begin
        exp_sh.push_back(k > 15 ? 15 : k);
        if ((k == 4 || k == 13) && exp_sh.size() < N) exp_sh.push_back(k);
        k++;
      end
    end
    while (idx < N && cycles < 1000) begin
      ea = 16'(exp_angle(m, exp_sh[idx], 16));
      vectors++;
      if (valid !== 1'b1) begin errors++; $display("FAIL valid: got %b expected 1 at step %0d", valid, idx); end
      vectors++;
      if (step !== 4'(idx)) begin errors++; $display("FAIL step: got %0d expected %0d", step, idx); end
      vectors++;
      if (shift !== 4'(exp_sh[idx])) begin errors++; $display("FAIL shift: got %0d expected %0d at step %0d", shift, exp_sh[idx], idx); end
      vectors++;
      if (angle !== ea) begin errors++; $display("FAIL angle: got %0d expected %0d at step %0d", angle, ea, idx); end
      if (idx < fixed_q.size()) begin
        vectors++;
        if (angle !== 16'(fixed_q[idx])) begin errors++; $display("FAIL angle_const: got %0d expected %0d at step %0d", angle, fixed_q[idx], idx); end
      end
      vectors++;
      if (last !== (idx == N - 1)) begin errors++; $display("FAIL last: got %b expected %b at step %0d", last, (idx == N - 1), idx); end
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL busy_done: got %b%b expected 10 at step %0d", busy, done, idx); end
      if (stall_at == idx && stalls < 3) begin
        ready = 1'b0;
        stalls++;
      end else begin
        ready = ($urandom_range(99) < ready_pct);
      end
      if (poke) begin
        start = 1'($urandom_range(1));
        mode  = 1'($urandom_range(1));
      end
      rdy = ready;
      tick();
      cycles++;
      if (rdy) idx++;
    end
    start = 1'b0;
    if (cycles >= 1000) begin
      vectors++; errors++;
      $display("FAIL run_timeout: got %0d accepted steps expected %0d", idx, N);
    end
    if (ready_pct == 100) begin
      vectors++;
      if (cycles !== N + (stall_at >= 0 ? 3 : 0)) begin errors++; $display("FAIL valid_cycles: got %0d expected %0d", cycles, N + (stall_at >= 0 ? 3 : 0)); end
    end
    vectors++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: got done=%b valid=%b busy=%b last=%b expected 1000", done, valid, busy, last);
    end
    $display("run mode=%0d ready_pct=%0d cycles=%0d", m, ready_pct, cycles);
    if (chain) begin
      start_run(chain_mode);
    end else begin
      tick();
      vectors++;
      if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_done: got done=%b valid=%b busy=%b expected 000", done, valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({valid, last, busy, done, shift, step, angle} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {valid, last, busy, done, shift, step, angle});
    end
    rst = 1'b0;
    ready = 1'b1;
    start_run(1'b0);
    for (int c = 0; c < 20 && step !== 4'd5; c++) tick();
    vectors++;
    if (step !== 4'd5) begin errors++; $display("FAIL reach_step5: got %0d expected 5", step); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({valid, last, busy, done, shift, step, angle} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: got %h expected 0", {valid, last, busy, done, shift, step, angle});
    end
    tick();
    vectors++;
    if (done !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL reset_no_done: got done=%b valid=%b expected 00", done, valid); end
    $display("reset mid-run at step 5 checked");
  endtask

  task automatic test_circular();
    fixed_q = {12868, 7596, 4014, 2037};
    start_run(1'b0);
    check_run(1'b0, 100, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hyperbolic();
    fixed_q = {9000, 4185, 2059, 1025, 1025};
    start_run(1'b1);
    check_run(1'b1, 100, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    fixed_q = {12868, 7596, 4014, 2037};
    start_run(1'b0);
    check_run(1'b0, 100, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_handling();
    fixed_q = {};
    start_run(1'b0);
    check_run(1'b0, 100, -1, 1'b1, 1'b1, 1'b1);
    check_run(1'b1, 100, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    bit m;
    fixed_q = {};
    for (int r = 0; r < 5; r++) begin
      m = 1'($urandom_range(1));
      start_run(m);
      check_run(m, 60, -1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_param_sweep();
    int steps = 0;
    int cyc = 0;
    pmode  = 1'b0;
    pready = 1'b1;
    pstart = 1'b1;
    tick();
    pstart = 1'b0;
    vectors++;
    if (a12 !== 12'd804) begin errors++; $display("FAIL wl12_angle0: got %0d expected 804", a12); end
    vectors++;
    if (a32 !== 32'd843314857) begin errors++; $display("FAIL wl32_angle0: got %0d expected 843314857", a32); end
    while (d12 !== 1'b1 && cyc < 20) begin
      if (v12 === 1'b1) begin
        vectors++;
        if (a12 !== 12'(exp_angle(1'b0, steps, 12)) || l12 !== (steps == 3)) begin
          errors++;
          $display("FAIL wl12_step: got angle=%0d last=%b expected angle=%0d last=%b", a12, l12, exp_angle(1'b0, steps, 12), (steps == 3));
        end
        steps++;
      end
      tick();
      cyc++;
    end
    vectors++;
    if (steps !== 4 || d12 !== 1'b1) begin errors++; $display("FAIL wl12_len: got %0d steps done=%b expected 4 steps done=1", steps, d12); end
    $display("param sweep wl12 steps=%0d", steps);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b0;
    pstart = 1'b0; pmode = 1'b0; pready = 1'b0;
    tick();
    tick();
    test_reset();
    test_circular();
    test_hyperbolic();
    test_stall();
    test_start_handling();
    test_back_to_back_random();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cordic_angle_sequencer.md
Name: cordic_angle_sequencer

Overview:
Parametrised, registered successor to the combinational arctan ROM used by the CORDIC vectoring datapath. It holds both the circular (atan 2^-i) and hyperbolic (artanh 2^-i) elementary-angle tables and steps through them autonomously once per accepted iteration. Each step presents the angle constant and its shift amount to the CORDIC core under a valid/ready handshake. In hyperbolic mode it applies the mandatory repeated iterations.

Parameters:
WORD_LENGTH, 16, angle word width; the angle is signed Q2.(WORD_LENGTH-2) radians; legal range 8..32.
ADDRESS_LENGTH, 4, width of the shift/index outputs; legal range 3..5.
N_ITER, 16, steps per run including hyperbolic repeats; 1 <= N_ITER <= 2^ADDRESS_LENGTH.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a run; sampled only in IDLE
mode  in  1  0 = circular (atan), 1 = hyperbolic (artanh); latched on an accepted start
ready  in  1  downstream accepts the current step
valid  out  1  step outputs are meaningful
shift  out  ADDRESS_LENGTH  shift amount k for this step (angle = f(2^-k))
step  out  ADDRESS_LENGTH  step counter, 0..N_ITER-1
angle  out  WORD_LENGTH  elementary angle constant for shift
last  out  1  high with valid on the final step
busy  out  1  high from an accepted start until done
done  out  1  one-cycle pulse after the final step is accepted

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; valid, last, busy and done all 0; shift, step and angle all 0. Reset aborts a run in progress; the next cycle is IDLE with no done pulse.
- States: IDLE, RUN.
- IDLE: on start=1, latch mode, busy<=1, valid<=1, step<=0. Load the first step in the same edge, so step-0 data is valid in the next cycle (latency 1).
- RUN: the step advances only on an edge where valid && ready; the outputs hold stable otherwise.
  - On acceptance of step N_ITER-1: valid<=0, last<=0, busy<=0, done<=1 for one cycle, return to IDLE.
  - start is ignored while busy, including in the done cycle's predecessor.
  - start sampled in the same cycle as done is accepted, because the state is already IDLE.
- Shift sequence, circular: shift = step (0,1,2,...).
- Shift sequence, hyperbolic: starts at 1; shifts 4 and 13 each occur twice, consecutively (1,2,3,4,4,5,...,12,13,13,14,...). The generator is a counter plus a repeat flag, not a lookup of step.
- last = valid && (step == N_ITER-1). It is registered alongside the other outputs.
- Angle table: a 32-bit master constant M(k) = round(f(2^-k) * 2^30), for k = 0..31 (atan) and k = 1..31 (artanh). Output angle = (M + 2^(s-1)) >> s with s = 32 - WORD_LENGTH; when s = 0, no rounding.
- angle, shift and step are registered and update together. There is no combinational path from ready to the outputs except through the flop enable.
- If a hyperbolic shift would exceed 2^ADDRESS_LENGTH - 1, it saturates at that value. This cannot occur for legal N_ITER at the defaults.
- done and valid are never high in the same cycle.

Test Plan:
- Reset mid-run: start a circular run, hold ready=1, assert rst at step 5 -> next cycle valid=0, busy=0, done=0, and all outputs read 0.
- Circular, defaults, ready=1: start -> the cycle after start has valid=1, shift=0, angle=12868.
  - Subsequent angles are 7596, 4014, 2037.
  - 16 valid cycles in total, with last high only at step 15.
  - done is high exactly one cycle after step 15 and low everywhere else.
- Hyperbolic, defaults: shift sequence is 1,2,3,4,4,5,...,13,13,14 over 16 steps.
  - Angles for shifts 1,2,3,4 are 9000, 4185, 2059, 1025; step 4 repeats 1025.
- Stall: circular run with ready=0 for 3 cycles at step 2 -> angle=4014 and step=2 hold stable for the stall; the run still ends after 16 accepted steps.
- Start handling: pulse start during RUN -> no restart. Assert start in the done cycle -> a new run begins, first valid on the next cycle.
  - A mode change while busy has no effect on the current run.
- Parameter sweep: WORD_LENGTH=12 with N_ITER=4 -> step-0 angle = 804, the run ends after 4 steps.
  - WORD_LENGTH=32 -> step-0 angle = 843314857.
